// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Parametrised UART receiver with configurable data width,
//               optional odd/even parity, 1 or 2 stop bits, 3-sample
//               majority voting, start-glitch rejection, parity/framing
//               error flags and a valid/ready handshake with overrun pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int DATA_WIDTH   = 8,
  parameter int BAUD_RATE    = 115200,
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  sysclk,
  input  logic                  rstn,
  input  logic                  uart_rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);

  localparam int c_BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
  localparam int c_HALF       = c_BIT_PERIOD / 2;
  localparam int c_CNT_W      = $clog2(c_BIT_PERIOD);
  localparam int c_IDX_W      = $clog2(DATA_WIDTH);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_BIT_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF  = c_CNT_W'(c_HALF);
  localparam logic [c_CNT_W-1:0] c_CNT_S1    = c_CNT_W'(c_HALF - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_S0    = c_CNT_W'(c_HALF - 2);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_WIDTH - 1);
  localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

  // Reject configurations the datapath cannot support.
  generate
    if (c_BIT_PERIOD < 8) begin : g_chk_period
      $error("uart_rx_cfg: bit period must be at least 8 clocks");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_chk_width
      $error("uart_rx_cfg: DATA_WIDTH must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  logic                  sync1_q, sync2_q;
  state_t                state_q;
  logic [c_CNT_W-1:0]    cnt_q;
  logic [c_IDX_W-1:0]    idx_q;
  logic                  stop_idx_q;
  logic                  samp0_q, samp1_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  perr_q, ferr_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  rx_valid_q, parity_err_q, frame_err_q, overrun_q;

  logic w_fall, w_mid, w_end, w_vote;

  // sync2_q is the older flop: a 1 there with a 0 behind it is a falling edge.
  assign w_fall = sync2_q & ~sync1_q;
  assign w_mid  = (cnt_q == c_CNT_HALF);
  assign w_end  = (cnt_q == c_CNT_LAST);
  assign w_vote = (samp0_q & samp1_q) | (samp0_q & sync2_q) | (samp1_q & sync2_q);

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // Frame state machine, bit timing, vote samples and registered outputs.
  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      stop_idx_q   <= 1'b0;
      samp0_q      <= 1'b1;
      samp1_q      <= 1'b1;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (state_q != S_IDLE) cnt_q <= w_end ? '0 : cnt_q + 1'b1;
      if (cnt_q == c_CNT_S0) samp0_q <= sync2_q;
      if (cnt_q == c_CNT_S1) samp1_q <= sync2_q;

      case (state_q)
        S_IDLE: begin
          if (w_fall) begin
            state_q    <= S_START;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end
        S_START: begin
          // A start bit that votes high was only a glitch.
          if (w_mid && w_vote) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (w_end) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_mid) shift_q <= {w_vote, shift_q[DATA_WIDTH-1:1]};
          if (w_end) begin
            if (idx_q == c_IDX_LAST) begin
              idx_q   <= '0;
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_mid) perr_q <= (PARITY == 1) ? ~(^shift_q ^ w_vote) : (^shift_q ^ w_vote);
          if (w_end) state_q <= S_STOP;
        end
        S_STOP: begin
          if (w_mid) begin
            if (stop_idx_q == c_STOP_LAST) begin
              // Complete at mid-bit so back-to-back frames can resync early.
              state_q      <= S_IDLE;
              cnt_q        <= '0;
              rx_data_q    <= shift_q;
              parity_err_q <= perr_q;
              frame_err_q  <= ferr_q | ~w_vote;
              rx_valid_q   <= 1'b1;
              overrun_q    <= rx_valid_q & ~rx_ready;
            end else begin
              ferr_q <= ferr_q | ~w_vote;
            end
          end
          if (w_end) stop_idx_q <= stop_idx_q + 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Self-checking bench for uart_rx_cfg. Four receivers with
//               different frame formats; directed table, corner sequences
//               and randomized frames checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  logic       sysclk = 1'b0;
  logic       rstn   = 1'b0;
  logic [3:0] line   = 4'hF;
  logic [3:0] ready  = 4'h0;
  logic [3:0] valid, perr, ferr, ovr, busy;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;

  int nvec  = 0;
  int nfail = 0;

  always #5 sysclk = ~sysclk;

  // u0: defaults (8N1, 434 clocks/bit); u1..u3: 16 clocks/bit variants.
  uart_rx_cfg u0 (
    .sysclk(sysclk), .rstn(rstn), .uart_rx(line[0]), .rx_data(d0), .rx_valid(valid[0]),
    .rx_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0]));
  uart_rx_cfg #(.DATA_WIDTH(8), .BAUD_RATE(100), .SYS_CLK_FREQ(1600), .PARITY(2), .STOP_BITS(1)) u1 (
    .sysclk(sysclk), .rstn(rstn), .uart_rx(line[1]), .rx_data(d1), .rx_valid(valid[1]),
    .rx_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1]));
  uart_rx_cfg #(.DATA_WIDTH(8), .BAUD_RATE(100), .SYS_CLK_FREQ(1600), .PARITY(1), .STOP_BITS(1)) u2 (
    .sysclk(sysclk), .rstn(rstn), .uart_rx(line[2]), .rx_data(d2), .rx_valid(valid[2]),
    .rx_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2]));
  uart_rx_cfg #(.DATA_WIDTH(5), .BAUD_RATE(100), .SYS_CLK_FREQ(1600), .PARITY(0), .STOP_BITS(2)) u3 (
    .sysclk(sysclk), .rstn(rstn), .uart_rx(line[3]), .rx_data(d3), .rx_valid(valid[3]),
    .rx_ready(ready[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]), .busy(busy[3]));

  // Frame format of each instance.
  function automatic int bp(input int k);    return (k == 0) ? 434 : 16; endfunction
  function automatic int wid(input int k);   return (k == 3) ? 5 : 8;    endfunction
  function automatic int pmode(input int k); return (k == 1) ? 2 : (k == 2) ? 1 : 0; endfunction
  function automatic int nstop(input int k); return (k == 3) ? 2 : 1;    endfunction

  function automatic logic [8:0] rxd(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {1'b0, d2};
      default: return {4'b0, d3};
    endcase
  endfunction

  // Observation of instance 0: start-to-valid latency, counts, accepted words.
  int          cyc = 0, t_busy = 0, lat0 = 0, vrise0 = 0, ovr0 = 0;
  logic        busy_p = 1'b0, valid_p = 1'b0;
  logic [10:0] acc0[$];

  always @(negedge sysclk) begin
    cyc     <= cyc + 1;
    busy_p  <= busy[0];
    valid_p <= valid[0];
    if (busy[0] && !busy_p) t_busy <= cyc;
    if (valid[0] && !valid_p) begin
      lat0   <= cyc - t_busy;
      vrise0 <= vrise0 + 1;
    end
    if (ovr[0]) ovr0 <= ovr0 + 1;
    if (valid[0] && ready[0]) acc0.push_back({perr[0], ferr[0], d0});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one frame bit by bit; spike inverts the line for one cycle at that
  // cycle offset; abort_at stops driving (line released high) at that offset.
  task automatic drive_frame(input int k, input logic [8:0] data, input logic pbit,
                             input logic [1:0] sbad, input int spike, input int abort_at);
    logic bits[$];
    int   n;
    bits.push_back(1'b0);
    for (int i = 0; i < wid(k); i++) bits.push_back(data[i]);
    if (pmode(k) != 0) bits.push_back(pbit);
    for (int i = 0; i < nstop(k); i++) bits.push_back(~sbad[i]);
    n = 0;
    foreach (bits[b]) begin
      for (int c = 0; c < bp(k); c++) begin
        if (n == abort_at) begin
          line[k] = 1'b1;
          return;
        end
        @(posedge sysclk); #1;
        line[k] = bits[b] ^ (n == spike);
        n++;
      end
    end
    @(posedge sysclk); #1;
    line[k] = 1'b1;
  endtask

  task automatic wait_valid(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge sysclk);
      if (valid[k]) break;
    end
    check("rx_valid_wait", {31'b0, valid[k]}, 32'd1);
  endtask

  task automatic accept(input int k);
    @(posedge sysclk); #1; ready[k] = 1'b1;
    @(posedge sysclk); #1; ready[k] = 1'b0;
    @(negedge sysclk);
    check("rx_valid_clear", {31'b0, valid[k]}, 32'd0);
  endtask

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] sbad;
    int         spike;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int          base, o, b, v, k;
    logic [8:0]  dat, edat;
    logic        pb, x, eperr, eferr;
    logic [1:0]  sb;
    int          spk;

    tbl[0] = '{0, 9'h092, 1'b0, 2'b00, -1,          9'h092, 1'b0, 1'b0};
    tbl[1] = '{0, 9'h03C, 1'b0, 2'b01, -1,          9'h03C, 1'b0, 1'b1};
    tbl[2] = '{0, 9'h06B, 1'b0, 2'b00, 4*434 + 216, 9'h06B, 1'b0, 1'b0};
    tbl[3] = '{1, 9'h0A5, 1'b0, 2'b00, -1,          9'h0A5, 1'b0, 1'b0};
    tbl[4] = '{1, 9'h0A5, 1'b1, 2'b00, -1,          9'h0A5, 1'b1, 1'b0};
    tbl[5] = '{2, 9'h0A5, 1'b1, 2'b00, -1,          9'h0A5, 1'b0, 1'b0};
    tbl[6] = '{2, 9'h0A5, 1'b0, 2'b00, -1,          9'h0A5, 1'b1, 1'b0};
    tbl[7] = '{3, 9'h015, 1'b0, 2'b00, -1,          9'h015, 1'b0, 1'b0};
    tbl[8] = '{3, 9'h015, 1'b0, 2'b10, -1,          9'h015, 1'b0, 1'b1};

    // Reset values.
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("reset_rx_data", {23'b0, rxd(0)}, 32'd0);
    check("reset_rx_valid", {28'b0, valid}, 32'd0);
    check("reset_parity_err", {28'b0, perr}, 32'd0);
    check("reset_frame_err", {28'b0, ferr}, 32'd0);
    check("reset_overrun", {28'b0, ovr}, 32'd0);
    check("reset_busy", {28'b0, busy}, 32'd0);
    @(posedge sysclk); #1; rstn = 1'b1;
    repeat (5) @(posedge sysclk);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      drive_frame(tbl[i].k, tbl[i].data, tbl[i].pbit, tbl[i].sbad, tbl[i].spike, -1);
      wait_valid(tbl[i].k, 4 * bp(tbl[i].k));
      check("tbl_rx_data", {23'b0, rxd(tbl[i].k)}, {23'b0, tbl[i].exp_data});
      check("tbl_parity_err", {31'b0, perr[tbl[i].k]}, {31'b0, tbl[i].exp_perr});
      check("tbl_frame_err", {31'b0, ferr[tbl[i].k]}, {31'b0, tbl[i].exp_ferr});
      if (i == 0) check("frame_latency", lat0, 9 * 434 + 217 + 1);
      accept(tbl[i].k);
      repeat (3) @(posedge sysclk);
    end

    // Start glitch of 100 cycles: busy pulses, nothing delivered.
    b = t_busy; v = vrise0;
    @(posedge sysclk); #1; line[0] = 1'b0;
    repeat (100) @(posedge sysclk);
    #1; line[0] = 1'b1;
    repeat (600) @(posedge sysclk);
    @(negedge sysclk);
    check("glitch_busy_seen", {31'b0, (t_busy != b)}, 32'd1);
    check("glitch_busy_low", {31'b0, busy[0]}, 32'd0);
    check("glitch_no_valid", vrise0, v);

    // Break: line low for 20 bit times yields exactly one 0x00 with frame_err.
    @(posedge sysclk); #1; ready[0] = 1'b1;
    base = acc0.size();
    line[0] = 1'b0;
    repeat (20 * 434) @(posedge sysclk);
    #1; line[0] = 1'b1;
    repeat (3 * 434) @(posedge sysclk);
    #1; ready[0] = 1'b0;
    repeat (2) @(posedge sysclk);
    check("break_words", acc0.size() - base, 1);
    if (acc0.size() > base) check("break_word", {21'b0, acc0[base]}, 32'h100);

    // Back-to-back with rx_ready low: one overrun, second word kept.
    o = ovr0;
    drive_frame(0, 9'h011, 1'b0, 2'b00, -1, -1);
    drive_frame(0, 9'h022, 1'b0, 2'b00, -1, -1);
    repeat (10) @(posedge sysclk);
    @(negedge sysclk);
    check("b2b_overrun_count", ovr0 - o, 1);
    check("b2b_rx_data", {23'b0, rxd(0)}, 32'h22);
    check("b2b_rx_valid", {31'b0, valid[0]}, 32'd1);

    // Reset in the middle of the data bits clears everything.
    drive_frame(0, 9'h0FF, 1'b0, 2'b00, -1, 4 * 434);
    rstn = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    check("midrst_rx_data", {23'b0, rxd(0)}, 32'd0);
    check("midrst_rx_valid", {31'b0, valid[0]}, 32'd0);
    check("midrst_flags", {29'b0, perr[0], ferr[0], ovr[0]}, 32'd0);
    check("midrst_busy", {31'b0, busy[0]}, 32'd0);
    @(posedge sysclk); #1; rstn = 1'b1;
    repeat (2 * 434) @(posedge sysclk);
    drive_frame(0, 9'h03C, 1'b0, 2'b00, -1, -1);
    wait_valid(0, 4 * 434);
    check("postrst_rx_data", {23'b0, rxd(0)}, 32'h3C);
    check("postrst_flags", {30'b0, perr[0], ferr[0]}, 32'd0);
    accept(0);

    // Back-to-back with rx_ready held high: both words accepted, no overrun.
    @(posedge sysclk); #1; ready[0] = 1'b1;
    base = acc0.size(); o = ovr0;
    drive_frame(0, 9'h011, 1'b0, 2'b00, -1, -1);
    drive_frame(0, 9'h022, 1'b0, 2'b00, -1, -1);
    repeat (300) @(posedge sysclk);
    #1; ready[0] = 1'b0;
    repeat (2) @(posedge sysclk);
    check("b2b_ready_words", acc0.size() - base, 2);
    if (acc0.size() >= base + 2) begin
      check("b2b_ready_first", {21'b0, acc0[base]}, 32'h011);
      check("b2b_ready_second", {21'b0, acc0[base + 1]}, 32'h022);
    end
    check("b2b_ready_overrun", ovr0 - o, 0);

    // Randomized frames on the fast instances against the frame-level model.
    for (int r = 0; r < 60; r++) begin
      k   = 1 + (r % 3);
      dat = 9'($urandom) & 9'((1 << wid(k)) - 1);
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (nstop(k) == 1) sb[1] = 1'b0;
      spk = ($urandom_range(0, 1) == 1) ?
            (1 + $urandom_range(0, wid(k) - 1)) * bp(k) + $urandom_range(0, bp(k) - 1) : -1;
      edat  = dat;
      x     = ^dat;
      eperr = (pmode(k) == 1) ? ((x ^ pb) != 1'b1) :
              (pmode(k) == 2) ? ((x ^ pb) != 1'b0) : 1'b0;
      eferr = (sb != 2'b00);
      drive_frame(k, dat, pb, sb, spk, -1);
      wait_valid(k, 4 * bp(k));
      check("rnd_rx_data", {23'b0, rxd(k)}, {23'b0, edat});
      check("rnd_parity_err", {31'b0, perr[k]}, {31'b0, eperr});
      check("rnd_frame_err", {31'b0, ferr[k]}, {31'b0, eferr});
      accept(k);
      repeat ($urandom_range(1, 16)) @(posedge sysclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
